// File: rtl/adc_multichannel_sequencer.sv
// adc_multichannel_sequencer: scans masked ADC mux channels in ascending order, tags each sample
// with its channel and streams it out. Define ADC_SCAN_OVERRUN_CNT_EN to add scan_overrun_count.
module adc_multichannel_sequencer #(
  parameter int DATA_WIDTH        = 16,
  parameter int NUM_CHANNELS      = 4,
  parameter int SAMPLE_RATE_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 200,
  parameter int MAX_RETRIES       = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic [NUM_CHANNELS-1:0]           channel_mask,
  input  logic [SAMPLE_RATE_WIDTH-1:0]      sample_rate_divider,
  input  logic [3:0]                        adc_settling_cycles,
  input  logic                              continuous_mode,
  input  logic                              trigger_scan,
  output logic                              adc_sample_request,
  output logic [$clog2(NUM_CHANNELS)-1:0]   adc_channel_sel,
  output logic                              adc_power_enable,
  output logic                              adc_reset_n,
  input  logic                              adc_ready,
  input  logic                              adc_data_valid,
  input  logic [DATA_WIDTH-1:0]             adc_data_in,
  input  logic                              adc_error,
  output logic                              data_valid_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic [$clog2(NUM_CHANNELS)-1:0]   data_channel_out,
  input  logic                              data_ready_in,
  output logic                              busy,
  output logic                              scan_done,
  output logic                              timeout_error,
  output logic                              interface_error,
  output logic [NUM_CHANNELS-1:0]           channel_fail_mask,
  output logic [15:0]                       samples_captured,
  output logic [2:0]                        state_out
`ifdef ADC_SCAN_OVERRUN_CNT_EN
  ,
  output logic [7:0]                        scan_overrun_count
`endif
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW   = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    POWER_UP  = 3'd1,
    ARMED     = 3'd2,
    SETTLE    = 3'd3,
    REQUEST   = 3'd4,
    WAIT_DATA = 3'd5,
    OUTPUT    = 3'd6,
    ERROR     = 3'd7
  } state_t;

  state_t                        state, state_nx;
  logic [SAMPLE_RATE_WIDTH-1:0]  scan_timer;
  logic                          trig_prev, enable_prev;
  logic [NUM_CHANNELS-1:0]       mask_lat, mask_nx;
  logic [CH_W-1:0]               ch, ch_nx;
  logic [RW-1:0]                 retry_cnt, retry_nx;
  logic [3:0]                    settle_cnt;
  logic [TW-1:0]                 wait_cnt;
  logic                          cause_to, cause_to_nx;
  logic                          done_nx, scan_done_r, fail_set;
  logic                          start_cond;
  logic [CH_W:0]                 first_hit, next_hit;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CHANNELS-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign start_cond = continuous_mode ? (scan_timer == sample_rate_divider)
                                      : (trigger_scan && !trig_prev);

  assign adc_power_enable   = (state != IDLE);
  assign adc_reset_n        = (state != IDLE) && (state != ERROR);
  assign adc_sample_request = (state == REQUEST);
  assign busy               = (state == SETTLE) || (state == REQUEST) || (state == WAIT_DATA) ||
                              (state == OUTPUT) || (state == ERROR);
  assign data_valid_out     = (state == OUTPUT);
  assign timeout_error      = (state == ERROR) && cause_to;
  assign interface_error    = (state == ERROR) && !cause_to;
  assign scan_done          = scan_done_r;
  assign state_out          = state;
  assign adc_channel_sel    = ch;

  always_comb begin
    state_nx    = state;
    ch_nx       = ch;
    retry_nx    = retry_cnt;
    mask_nx     = mask_lat;
    cause_to_nx = cause_to;
    done_nx     = 1'b0;
    fail_set    = 1'b0;
    first_hit   = find_from(channel_mask, 0);
    next_hit    = find_from(mask_lat, int'(ch) + 1);
    case (state)
      IDLE:     if (enable) state_nx = POWER_UP;
      POWER_UP: state_nx = ARMED;
      ARMED: begin
        if (start_cond) begin
          mask_nx = channel_mask;
          if (first_hit[CH_W]) begin
            ch_nx    = first_hit[CH_W-1:0];
            retry_nx = '0;
            state_nx = SETTLE;
          end
        end
      end
      SETTLE:   if (settle_cnt == adc_settling_cycles) state_nx = REQUEST;
      REQUEST: begin
        if (adc_ready) state_nx = WAIT_DATA;
        else if (adc_error) begin
          state_nx    = ERROR;
          cause_to_nx = 1'b0;
        end
      end
      WAIT_DATA: begin
        if (adc_data_valid) state_nx = OUTPUT;
        else if (adc_error) begin
          state_nx    = ERROR;
          cause_to_nx = 1'b0;
        end else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nx    = ERROR;
          cause_to_nx = 1'b1;
        end
      end
      OUTPUT: begin
        if (data_ready_in) begin
          if (!enable) begin
            state_nx = IDLE;
            ch_nx    = '0;
            retry_nx = '0;
            mask_nx  = '0;
          end else if (next_hit[CH_W]) begin
            ch_nx    = next_hit[CH_W-1:0];
            retry_nx = '0;
            state_nx = SETTLE;
          end else begin
            done_nx  = 1'b1;
            state_nx = ARMED;
          end
        end
      end
      ERROR: begin
        if (retry_cnt < RW'(MAX_RETRIES)) begin
          retry_nx = retry_cnt + RW'(1);
          state_nx = SETTLE;
        end else begin
          fail_set = 1'b1;
          retry_nx = '0;
          if (next_hit[CH_W]) begin
            ch_nx    = next_hit[CH_W-1:0];
            state_nx = SETTLE;
          end else begin
            done_nx  = 1'b1;
            state_nx = ARMED;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    // Losing enable abandons the scan everywhere except mid-handshake.
    if (!enable && state != OUTPUT) begin
      state_nx = IDLE;
      ch_nx    = '0;
      retry_nx = '0;
      mask_nx  = '0;
      done_nx  = 1'b0;
      fail_set = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      retry_cnt   <= '0;
      mask_lat    <= '0;
      cause_to    <= 1'b0;
      scan_done_r <= 1'b0;
      settle_cnt  <= '0;
      wait_cnt    <= '0;
      trig_prev   <= 1'b0;
      enable_prev <= 1'b0;
    end else begin
      state       <= state_nx;
      ch          <= ch_nx;
      retry_cnt   <= retry_nx;
      mask_lat    <= mask_nx;
      cause_to    <= cause_to_nx;
      scan_done_r <= done_nx;
      settle_cnt  <= (state == SETTLE) ? settle_cnt + 4'd1 : 4'd0;
      wait_cnt    <= (state == WAIT_DATA) ? wait_cnt + TW'(1) : '0;
      trig_prev   <= trigger_scan;
      enable_prev <= enable;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable || state == IDLE) scan_timer <= '0;
    else if (scan_timer == sample_rate_divider) scan_timer <= '0;
    else scan_timer <= scan_timer + SAMPLE_RATE_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || (enable && !enable_prev)) channel_fail_mask <= '0;
    else if (fail_set) channel_fail_mask[ch] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) samples_captured <= '0;
    else if (state == OUTPUT && data_ready_in) samples_captured <= samples_captured + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out         <= '0;
      data_channel_out <= '0;
    end else if (state == WAIT_DATA && adc_data_valid) begin
      data_out         <= adc_data_in;
      data_channel_out <= ch;
    end
  end

`ifdef ADC_SCAN_OVERRUN_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || !enable) scan_overrun_count <= '0;
    else if (start_cond && busy && scan_overrun_count != 8'hFF)
      scan_overrun_count <= scan_overrun_count + 8'd1;
  end
`endif

endmodule

// File: doc/adc_multichannel_sequencer.md
Name: adc_multichannel_sequencer

Overview:
- Next-generation ADC front-end controller.
- Scans up to NUM_CHANNELS multiplexed ADC inputs in ascending index order, per scan, under a latched channel mask.
- Tags each sample with its channel ID and streams it over a valid/ready interface to the sample FIFO / processing pipeline.
- Adds three behaviours: per-channel retry with sticky failure flags, parametrised timeout, and scan-level pacing in continuous or triggered mode.

Parameters:
- DATA_WIDTH, 16, ADC sample width.
- NUM_CHANNELS, 4, number of mux channels (2..16); CH_W = $clog2(NUM_CHANNELS), localparam.
- SAMPLE_RATE_WIDTH, 16, scan-period divider width.
- TIMEOUT_CYCLES, 200, max cycles in WAIT_DATA before a timeout.
- MAX_RETRIES, 2, retries per channel per scan after the first failure.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  block enable.
- channel_mask  in  NUM_CHANNELS  channels to scan; latched at scan start.
- sample_rate_divider  in  SAMPLE_RATE_WIDTH  scan period in cycles minus 1.
- adc_settling_cycles  in  4  mux settling cycles after each channel switch.
- continuous_mode  in  1  1 = timer-paced scans; 0 = triggered scans.
- trigger_scan  in  1  rising edge starts one scan (triggered mode).
- adc_sample_request  out  1  conversion request.
- adc_channel_sel  out  CH_W  mux select.
- adc_power_enable  out  1  ADC power.
- adc_reset_n  out  1  ADC reset, active low.
- adc_ready  in  1  accepts the request.
- adc_data_valid  in  1  conversion result valid.
- adc_data_in  in  DATA_WIDTH  conversion result.
- adc_error  in  1  ADC fault.
- data_valid_out  out  1  output beat valid.
- data_out  out  DATA_WIDTH  sample.
- data_channel_out  out  CH_W  channel tag of the sample.
- data_ready_in  in  1  downstream ready.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at end of scan.
- timeout_error  out  1  one-cycle pulse per timeout.
- interface_error  out  1  one-cycle pulse per adc_error.
- channel_fail_mask  out  NUM_CHANNELS  sticky per-channel failure flags.
- samples_captured  out  16  accepted output beats, wrapping.
- state_out  out  3  state encoding, for debug.

Behaviour:
- Reset: state IDLE. Every output is 0, including adc_reset_n = 0, channel_fail_mask = 0 and samples_captured = 0.
- States: IDLE=0, POWER_UP=1, ARMED=2, SETTLE=3, REQUEST=4, WAIT_DATA=5, OUTPUT=6, ERROR=7.
- Output decode is Moore, from the state register:
  - adc_power_enable = 1 in all states except IDLE.
  - adc_reset_n = 1 except in IDLE and ERROR.
  - adc_sample_request = 1 only in REQUEST.
  - busy = 1 in SETTLE, REQUEST, WAIT_DATA, OUTPUT and ERROR.
- IDLE -> POWER_UP when enable = 1. POWER_UP -> ARMED after 1 cycle.
- Scan start, evaluated only in ARMED:
  - Continuous mode: the scan timer counts 0..sample_rate_divider, then wraps, while enable is high and the state is not IDLE. Start when the timer equals the divider.
  - Triggered mode: start on trigger_scan rising edge, using a registered previous value.
  - Start conditions arriving outside ARMED are dropped, not queued.
- At scan start, latch channel_mask. If the latched mask is 0, stay in ARMED with no scan_done.
- Otherwise select the lowest set channel, drive adc_channel_sel and go to SETTLE.
- SETTLE lasts adc_settling_cycles + 1 cycles (a value of 0 gives 1 cycle), then goes to REQUEST.
- REQUEST:
  - adc_ready -> WAIT_DATA.
  - else adc_error -> ERROR.
  - else hold.
- WAIT_DATA: the counter clears on entry.
  - adc_data_valid -> capture adc_data_in and the channel, go to OUTPUT.
  - else adc_error, or counter = TIMEOUT_CYCLES-1 -> ERROR.
  - Priority when simultaneous: valid > adc_error > timeout.
- OUTPUT: data_valid_out = 1 with data and tag stable until data_ready_in = 1.
  - On the handshake cycle, samples_captured increments (16-bit wrap).
  - The next set mask bit above the current one -> SETTLE on that channel.
  - If none remain: pulse scan_done and go to ARMED.
- ERROR lasts 1 cycle: timeout_error or interface_error pulses, according to the cause.
  - If the retry count for this channel is < MAX_RETRIES: increment it, go to SETTLE on the same channel.
  - Otherwise set channel_fail_mask[ch] and advance as from OUTPUT, with no beat emitted.
  - The retry count clears on each channel advance.
- channel_fail_mask clears only on reset, or on enable rising from 0 to 1.
- enable = 0 in any state except OUTPUT: go to IDLE next cycle and clear the scan context.
- enable = 0 in OUTPUT: finish the handshake, then go to IDLE.
- samples_captured clears while enable = 0.
- Synchronous reset mid-scan: the next cycle is exactly the reset state; no pending beat survives.

Optional Feature:
- Macro ADC_SCAN_OVERRUN_CNT_EN.
- Defined: adds output scan_overrun_count (8 bits, saturating at 255, reset 0, cleared while enable = 0). It increments on each scan-start condition that occurs while busy = 1.
- Undefined: the port is absent and such conditions are silently dropped. All other behaviour is identical.

Test Plan:
- Continuous mode, mask=4'b1011, divider=99, settling=2, ADC answers ready and valid 3 cycles after request, sink always ready -> beats tagged 0,1,3 in order, one scan_done per 100-cycle period, samples_captured=3 after the first scan.
- Triggered mode, mask=4'b0100, one trigger_scan pulse held high 5 cycles -> exactly one beat with tag 2, trigger level does not retrigger, state returns to ARMED (2).
- Channel 1 never asserts adc_data_valid, TIMEOUT_CYCLES=200, MAX_RETRIES=2 -> three timeout_error pulses each 200 cycles after entering WAIT_DATA, channel_fail_mask=4'b0010, scan continues to channel 3.
- data_ready_in held low 50 cycles in OUTPUT -> data_out and tag stable for the whole stall, one increment on acceptance; adc_data_valid and adc_error asserted together in WAIT_DATA -> data is taken and no error is raised.
- enable dropped during WAIT_DATA -> IDLE next cycle with adc_power_enable=0. Separately, reset asserted mid-SETTLE -> all outputs 0 on the following cycle.
- With ADC_SCAN_OVERRUN_CNT_EN, divider=9 and a scan longer than 10 cycles -> scan_overrun_count increments once per missed period and saturates at 255.
